// File: rtl/logic_op_unit.sv
// logic_op_unit: registered bitwise operation unit with valid/ready handshake,
// AND/OR accumulate modes, a reduction bit, a popcount of the result and a
// saturating count of accepted transactions.
module logic_op_unit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [2:0]                   op,
    input  logic                         acc_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             y,
    output logic                         y_red,
    output logic [$clog2(WIDTH+1)-1:0]   ones,
    output logic [CNT_W-1:0]             txn_cnt
);

    localparam int ONES_W = $clog2(WIDTH+1);

    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_OR      = 3'b001;
    localparam logic [2:0] OP_XOR     = 3'b010;
    localparam logic [2:0] OP_NAND    = 3'b011;
    localparam logic [2:0] OP_NOR     = 3'b100;
    localparam logic [2:0] OP_XNOR    = 3'b101;
    localparam logic [2:0] OP_ACC_AND = 3'b110;
    localparam logic [2:0] OP_ACC_OR  = 3'b111;

    // Number of set bits in v.
    function automatic logic [ONES_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [ONES_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + ONES_W'(v[i]);
        end
        return n;
    endfunction

    // Reduction matched to the operation family: AND-like ops reduce with AND,
    // OR-like ops with OR, XOR-like ops with XOR.
    function automatic logic reduce(input logic [2:0] sel, input logic [WIDTH-1:0] v);
        logic r;
        case (sel)
            OP_AND, OP_NAND, OP_ACC_AND: r = &v;
            OP_OR,  OP_NOR,  OP_ACC_OR:  r = |v;
            default:                     r = ^v;
        endcase
        return r;
    endfunction

    logic             accept;
    logic             is_acc_op;
    logic [WIDTH-1:0] t_and_p0;
    logic [WIDTH-1:0] t_or_p0;
    logic [WIDTH-1:0] acc_cur_p0;
    logic             acc_empty_cur_p0;
    logic [WIDTH-1:0] acc_nxt_p0;
    logic [WIDTH-1:0] r_p0;
    logic [WIDTH-1:0] acc_p1;
    logic             acc_empty_p1;

    // Ready is withheld in reset, when disabled, or while an unconsumed result is held.
    assign in_ready  = rst_n & ena & (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign is_acc_op = (op == OP_ACC_AND) || (op == OP_ACC_OR);

    // Input stage: compute the result; a same-cycle clear is seen by the accumulate ops first.
    always_comb begin
        t_and_p0         = a & b;
        t_or_p0          = a | b;
        acc_empty_cur_p0 = acc_empty_p1 | acc_clr;
        acc_cur_p0       = acc_clr ? '0 : acc_p1;
        acc_nxt_p0       = acc_cur_p0;
        r_p0             = '0;
        case (op)
            OP_AND:  r_p0 = t_and_p0;
            OP_OR:   r_p0 = t_or_p0;
            OP_XOR:  r_p0 = a ^ b;
            OP_NAND: r_p0 = ~t_and_p0;
            OP_NOR:  r_p0 = ~t_or_p0;
            OP_XNOR: r_p0 = ~(a ^ b);
            OP_ACC_AND: begin
                acc_nxt_p0 = acc_empty_cur_p0 ? t_and_p0 : (acc_cur_p0 & t_and_p0);
                r_p0       = acc_nxt_p0;
            end
            OP_ACC_OR: begin
                acc_nxt_p0 = acc_empty_cur_p0 ? t_or_p0 : (acc_cur_p0 | t_or_p0);
                r_p0       = acc_nxt_p0;
            end
            default: r_p0 = '0;
        endcase
    end

    // Output stage: load on accept, drain when taken, hold under backpressure or while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            y_red     <= 1'b0;
            ones      <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= r_p0;
            y_red     <= reduce(op, r_p0);
            ones      <= popcount(r_p0);
        end else if (ena && out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Accumulator: updated by accepted accumulate ops, otherwise cleared by acc_clr regardless of ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_p1       <= '0;
            acc_empty_p1 <= 1'b1;
        end else if (accept && is_acc_op) begin
            acc_p1       <= acc_nxt_p0;
            acc_empty_p1 <= 1'b0;
        end else if (acc_clr) begin
            acc_p1       <= '0;
            acc_empty_p1 <= 1'b1;
        end
    end

    // Transaction counter: counts accepts and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txn_cnt <= '0;
        end else if (accept && (txn_cnt != {CNT_W{1'b1}})) begin
            txn_cnt <= txn_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_op_unit.sv
// Testbench for logic_op_unit: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of the unit.
module tb_logic_op_unit;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       acc_clr;
    logic       out_ready;

    logic       in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic [3:0] y,         y2;
    logic       y_red,     y_red2;
    logic [2:0] ones,      ones2;
    logic [7:0] txn_cnt;
    logic [1:0] txn_cnt2;

    int checks   = 0;
    int failures = 0;
    logic mon_en;

    logic_op_unit #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .y_red(y_red), .ones(ones), .txn_cnt(txn_cnt)
    );

    logic_op_unit #(.WIDTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .op(op), .acc_clr(acc_clr), .out_valid(out_valid2),
        .out_ready(out_ready), .y(y2), .y_red(y_red2), .ones(ones2), .txn_cnt(txn_cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic       m_valid;
    logic [3:0] m_y;
    logic       m_red;
    int         m_ones;
    int         m_n;
    logic [3:0] m_acc;
    logic       m_empty;

    function automatic logic [3:0] plain_op(input logic [2:0] o, input logic [3:0] x, input logic [3:0] z);
        case (o)
            3'd0: return x & z;
            3'd1: return x | z;
            3'd2: return x ^ z;
            3'd3: return ~(x & z);
            3'd4: return ~(x | z);
            default: return ~(x ^ z);
        endcase
    endfunction

    function automatic logic red_of(input logic [2:0] o, input logic [3:0] r);
        if (o == 3'd0 || o == 3'd3 || o == 3'd6) return &r;
        if (o == 3'd1 || o == 3'd4 || o == 3'd7) return |r;
        return ^r;
    endfunction

    always @(posedge clk) begin
        logic       rdy;
        logic [3:0] t;
        logic [3:0] r;
        if (!rst_n) begin
            m_valid = 1'b0; m_y = 4'd0; m_red = 1'b0; m_ones = 0; m_n = 0;
            m_acc = 4'd0; m_empty = 1'b1;
        end else begin
            rdy = ena && (!m_valid || out_ready);
            if (acc_clr) begin
                m_acc = 4'd0;
                m_empty = 1'b1;
            end
            if (in_valid && rdy) begin
                if (op == 3'd6 || op == 3'd7) begin
                    t = (op == 3'd6) ? (a & b) : (a | b);
                    if (m_empty) m_acc = t;
                    else m_acc = (op == 3'd6) ? (m_acc & t) : (m_acc | t);
                    m_empty = 1'b0;
                    r = m_acc;
                end else begin
                    r = plain_op(op, a, b);
                end
                m_y = r;
                m_red = red_of(op, r);
                m_ones = $countones(r);
                m_valid = 1'b1;
                m_n++;
            end else if (ena && m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_out_valid", out_valid, m_valid);
            chk("mon_in_ready", in_ready, rst_n && ena && (!m_valid || out_ready));
            chk("mon_txn_cnt", txn_cnt, (m_n > 255) ? 255 : m_n);
            chk("mon_txn_cnt_sat", txn_cnt2, (m_n > 3) ? 3 : m_n);
            if (m_valid) begin
                chk("mon_y", y, m_y);
                chk("mon_y_red", y_red, m_red);
                chk("mon_ones", ones, m_ones);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] exp_y    [6] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001};
    logic       exp_red  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int         exp_ones [6] = '{1, 3, 2, 3, 1, 2};

    initial begin
        mon_en = 1'b0;
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b1; a = 4'd0; b = 4'd0;
        op = 3'd0; acc_clr = 1'b0; out_ready = 1'b1;

        // reset with in_valid high
        tick();
        mon_en = 1'b1;
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_txn_cnt", txn_cnt, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // plain ops on 1100 / 1010
        for (int i = 0; i < 6; i++) begin
            op = 3'(i); a = 4'b1100; b = 4'b1010; in_valid = 1'b1;
            tick();
            chk("op_y", y, exp_y[i]);
            chk("op_y_red", y_red, exp_red[i]);
            chk("op_ones", ones, exp_ones[i]);
        end
        in_valid = 1'b0;

        // accumulate after a clear
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        in_valid = 1'b1; op = 3'd6; a = 4'b1111; b = 4'b1110;
        tick();
        chk("accand1_y", y, 4'b1110);
        a = 4'b1011; b = 4'b1111;
        tick();
        chk("accand2_y", y, 4'b1010);
        chk("accand2_ones", ones, 2);
        acc_clr = 1'b1; op = 3'd7; a = 4'b0001; b = 4'b0000;
        tick();
        chk("clr_accor_y", y, 4'b0001);
        chk("clr_accor_red", y_red, 1);
        acc_clr = 1'b0;

        // plain op leaves acc alone; ACC_OR combines with it
        op = 3'd0; a = 4'b1111; b = 4'b0000;
        tick();
        chk("and_zero_y", y, 4'b0000);
        op = 3'd7; a = 4'b0100; b = 4'b0000;
        tick();
        chk("accor_mix_y", y, 4'b0101);
        chk("accor_mix_ones", ones, 2);

        // backpressure
        op = 3'd2; a = 4'b1111; b = 4'b0101;
        tick();
        chk("bp_first_y", y, 4'b1010);
        out_ready = 1'b0; op = 3'd1; a = 4'b0001; b = 4'b0010;
        #1;
        chk("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_y", y, 4'b1010);
            chk("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_next_y", y, 4'b0011);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", out_valid, 0);
        chk("bp_txn_cnt", txn_cnt, 13);
        chk("bp_txn_cnt_sat", txn_cnt2, 3);

        // clear with ena low still empties the accumulator
        in_valid = 1'b1; op = 3'd7; a = 4'b1100; b = 4'b0000;
        tick();
        chk("fill_y", y, 4'b1101);
        in_valid = 1'b0; ena = 1'b0; acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0; ena = 1'b1; in_valid = 1'b1; a = 4'b0011;
        tick();
        chk("clr_ena0_y", y, 4'b0011);

        // reset with a pending result
        op = 3'd0; a = 4'b1111; b = 4'b1111; out_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_txn_cnt", txn_cnt, 0);
        chk("midrst_in_ready", in_ready, 0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // continuous XOR flow
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = 3'd2; a = 4'(i); b = 4'b1111;
            tick();
            chk("flow_y", y, 4'(i) ^ 4'b1111);
            chk("flow_valid", out_valid, 1);
            if (i == 4) begin
                chk("flow5_txn_cnt", txn_cnt, 5);
                chk("flow5_txn_cnt_sat", txn_cnt2, 3);
            end
        end
        chk("flow_txn_cnt", txn_cnt, 10);
        chk("flow_txn_cnt_sat", txn_cnt2, 3);

        // disabled: nothing accepted, output held
        ena = 1'b0; a = 4'b0101;
        #1;
        chk("ena0_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ena0_txn_cnt", txn_cnt, 10);
            chk("ena0_valid", out_valid, 1);
            chk("ena0_y", y, 4'b0110);
        end
        ena = 1'b1; in_valid = 1'b0;
        tick();
        chk("ena1_drain_valid", out_valid, 0);
        chk("ena1_txn_cnt", txn_cnt, 10);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
